ms_mul_sched: RTL and testbench

Round-robin scheduler sharing one ordered-bitstream stochastic multiplier core among NUM_REQ requesters. Accepts one operand set at a time, holds it stable on the core, runs the core until done or timeout, and integrates the core's output bitstream into a binary product. Returns a tagged response on a single valid/ready channel. Sits between requester front-ends and the multiplier core wrapper.

---
 rtl/ms_mul_sched_pkg.sv | 30 +++
 rtl/ms_rr_pick.sv | 24 ++
 rtl/ms_mul_sched.sv | 162 ++++++++++++++++
 tb/tb_ms_mul_sched.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ms_mul_sched_pkg.sv
// Shared types and sizing helpers for the stochastic-multiplier scheduler.
package ms_mul_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_e;

    // Widest core output word the popcount helper accepts.
    localparam int POPCNT_MAX_W = 64;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int acc_w(input longint timeout, input int wxip1);
        return $clog2(timeout * longint'(wxip1) + 64'sd1);
    endfunction

    function automatic int unsigned popcount(input logic [POPCNT_MAX_W-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < POPCNT_MAX_W; i++) begin
            c += 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/ms_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr, wrapping.
module ms_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             any_o
);

    // Walk offsets from farthest to nearest so the nearest valid wins without a break.
    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        for (int off = N - 1; off >= 0; off--) begin
            if (valid_i[(int'(ptr_i) + off) % N]) begin
                grant_o = IDX_W'((int'(ptr_i) + off) % N);
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ms_mul_sched.sv
// Round-robin scheduler sharing one ordered-bitstream stochastic multiplier core;
// integrates the core's output bitstream into a tagged, saturating product count.
module ms_mul_sched
    import ms_mul_sched_pkg::*;
#(
    parameter int  DATA_WIDTH = 5,
    parameter int  NUM_INPUTS = 2,
    parameter int  WXIP1      = 1,
    parameter int  NUM_REQ    = 4,
    parameter int  TIMEOUT    = 2 ** (2 * DATA_WIDTH),
    parameter int  ACC_W      = acc_w(TIMEOUT, WXIP1),
    localparam int ID_W       = id_w(NUM_REQ)
) (
    input  logic                                             gclk,
    input  logic                                             rst_n,
    input  logic [NUM_REQ-1:0]                               req_valid,
    output logic [NUM_REQ-1:0]                               req_ready,
    input  logic [NUM_REQ-1:0][NUM_INPUTS-1:0][DATA_WIDTH-1:0] req_data,
    output logic                                             resp_valid,
    input  logic                                             resp_ready,
    output logic [ID_W-1:0]                                  resp_id,
    output logic [ACC_W-1:0]                                 resp_data,
    output logic                                             resp_err,
    output logic                                             core_rst,
    output logic                                             core_en,
    output logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]            core_data,
    input  logic [WXIP1-1:0]                                 core_out,
    input  logic                                             core_done,
    output logic                                             busy
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int PC_W  = $clog2(WXIP1 + 1);

    state_e                                  state_q, state_d;
    logic [ID_W-1:0]                         ptr_q, ptr_d;
    logic [ACC_W-1:0]                        acc_q, acc_d;
    logic [CNT_W-1:0]                        cnt_q, cnt_d;
    logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]   core_data_q, core_data_d;
    logic [ID_W-1:0]                         resp_id_q, resp_id_d;
    logic [ACC_W-1:0]                        resp_data_q, resp_data_d;
    logic                                    resp_err_q, resp_err_d;
    logic                                    resp_valid_q;
    logic                                    core_en_q;
    logic                                    core_rst_q;
    logic                                    busy_q;

    logic [ID_W-1:0]                         grant;
    logic                                    any_valid;
    logic [POPCNT_MAX_W-1:0]                 core_out_ext;
    logic [PC_W-1:0]                         pc;
    logic [ACC_W:0]                          acc_sum;
    logic [ACC_W-1:0]                        acc_sat;
    logic                                    cnt_last;

    ms_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .any_o   (any_valid)
    );

    // One extra accumulator bit catches overflow; clamp to all-ones on carry.
    always_comb begin
        core_out_ext = POPCNT_MAX_W'(core_out);
        pc           = PC_W'(popcount(core_out_ext));
        acc_sum      = {1'b0, acc_q} + (ACC_W + 1)'(pc);
        acc_sat      = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
        cnt_last     = (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        core_data_d = core_data_q;
        resp_id_d   = resp_id_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        req_ready   = '0;
        unique case (state_q)
            IDLE: begin
                if (any_valid && rst_n) begin
                    req_ready[grant] = 1'b1;
                    core_data_d      = req_data[grant];
                    resp_id_d        = grant;
                    acc_d            = '0;
                    cnt_d            = '0;
                    state_d          = RUN;
                end
            end
            RUN: begin
                acc_d = acc_sat;
                cnt_d = cnt_q + CNT_W'(1);
                // A done in the final cycle wins over the timeout.
                if (core_done) begin
                    resp_data_d = acc_sat;
                    resp_err_d  = 1'b0;
                    state_d     = RESP;
                end else if (cnt_last) begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    ptr_d   = (resp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : resp_id_q + ID_W'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            core_data_q  <= '0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            core_en_q    <= 1'b0;
            core_rst_q   <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            core_data_q  <= core_data_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            resp_valid_q <= (state_d == RESP);
            core_en_q    <= (state_d == RUN);
            core_rst_q   <= (state_d != RUN);
            busy_q       <= (state_d != IDLE);
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign core_rst   = core_rst_q;
    assign core_en    = core_en_q;
    assign core_data  = core_data_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ms_mul_sched.sv
// Directed bench for ms_mul_sched: arbitration order, result integration, timeout,
// response back-pressure, mid-run reset and accumulator saturation.
module tb_ms_mul_sched;

    localparam int DW = 5;
    localparam int NI = 2;
    localparam int NR = 4;

    logic gclk = 1'b0;
    always #5 gclk = ~gclk;

    logic rst_n;

    // Instance A: TIMEOUT=16, single-bit core output.
    logic [NR-1:0]              req_valid, req_ready;
    logic [NR-1:0][NI-1:0][DW-1:0] req_data;
    logic                       resp_valid, resp_ready, resp_err;
    logic [1:0]                 resp_id;
    logic [4:0]                 resp_data;
    logic                       core_rst, core_en, core_done, busy;
    logic [NI-1:0][DW-1:0]      core_data;
    logic [0:0]                 core_out;

    // Instance B: WXIP1=4, TIMEOUT=300, ACC_W=8.
    logic [NR-1:0]              b_req_valid, b_req_ready;
    logic [NR-1:0][NI-1:0][DW-1:0] b_req_data;
    logic                       b_resp_valid, b_resp_ready, b_resp_err;
    logic [1:0]                 b_resp_id;
    logic [7:0]                 b_resp_data;
    logic                       b_core_rst, b_core_en, b_core_done, b_busy;
    logic [NI-1:0][DW-1:0]      b_core_data;
    logic [3:0]                 b_core_out;

    int total = 0;
    int bad   = 0;

    // Core stub for A: ones_len one-bits from the first RUN cycle, done in RUN cycle done_at.
    int stub_cnt = 0;
    int ones_len = 0;
    int done_at  = -1;
    always @(posedge gclk) begin
        if (!core_en) stub_cnt <= 0;
        else          stub_cnt <= stub_cnt + 1;
    end
    assign core_out  = (core_en && stub_cnt < ones_len) ? 1'b1 : 1'b0;
    assign core_done = core_en && (done_at >= 0) && (stub_cnt == done_at);

    int stub_b_cnt = 0;
    always @(posedge gclk) begin
        if (!b_core_en) stub_b_cnt <= 0;
        else            stub_b_cnt <= stub_b_cnt + 1;
    end
    assign b_core_out  = b_core_en ? 4'b1111 : 4'b0000;
    assign b_core_done = b_core_en && (stub_b_cnt == 299);

    ms_mul_sched #(
        .DATA_WIDTH (DW), .NUM_INPUTS (NI), .WXIP1 (1), .NUM_REQ (NR),
        .TIMEOUT (16), .ACC_W (5)
    ) dut_a (
        .gclk (gclk), .rst_n (rst_n),
        .req_valid (req_valid), .req_ready (req_ready), .req_data (req_data),
        .resp_valid (resp_valid), .resp_ready (resp_ready), .resp_id (resp_id),
        .resp_data (resp_data), .resp_err (resp_err),
        .core_rst (core_rst), .core_en (core_en), .core_data (core_data),
        .core_out (core_out), .core_done (core_done), .busy (busy)
    );

    ms_mul_sched #(
        .DATA_WIDTH (DW), .NUM_INPUTS (NI), .WXIP1 (4), .NUM_REQ (NR),
        .TIMEOUT (300), .ACC_W (8)
    ) dut_b (
        .gclk (gclk), .rst_n (rst_n),
        .req_valid (b_req_valid), .req_ready (b_req_ready), .req_data (b_req_data),
        .resp_valid (b_resp_valid), .resp_ready (b_resp_ready), .resp_id (b_resp_id),
        .resp_data (b_resp_data), .resp_err (b_resp_err),
        .core_rst (b_core_rst), .core_en (b_core_en), .core_data (b_core_data),
        .core_out (b_core_out), .core_done (b_core_done), .busy (b_busy)
    );

    task automatic step();
        @(posedge gclk);
        #1;
    endtask

    // Drives one operation on A through to its response; reports ok=0 if a wait bound expires.
    task automatic run_op(input bit ack, output int id, output int data, output bit err,
                          output int lat, output bit ok);
        int w;
        ok = 1'b1; id = -1; data = -1; err = 1'bx; lat = 0; w = 0;
        while (!busy && w < 50) begin step(); w++; end
        if (!busy) ok = 1'b0;
        else begin
            while (!resp_valid && lat < 100) begin step(); lat++; end
            if (!resp_valid) ok = 1'b0;
            else begin
                id = int'(resp_id); data = int'(resp_data); err = resp_err;
                if (ack) begin resp_ready = 1'b1; step(); resp_ready = 1'b0; end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 4'b1111; resp_ready = 1'b0; req_data = '0;
        b_req_valid = '0; b_resp_ready = 1'b0; b_req_data = '0;
        step(); step();
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        total++; if ({resp_valid, resp_err, busy, core_en, core_rst} !== 5'b00001)
            begin bad++; $display("FAIL reset_ctrl got v=%b e=%b busy=%b en=%b rst=%b want 0 0 0 0 1", resp_valid, resp_err, busy, core_en, core_rst); end
        total++; if (resp_id !== 2'd0 || resp_data !== 5'd0 || core_data !== '0)
            begin bad++; $display("FAIL reset_data got id=%0d data=%0d core=%h want 0 0 0", resp_id, resp_data, core_data); end
    endtask

    task automatic test_round_robin();
        int exp1[4] = '{0, 1, 2, 3};
        int exp2[2] = '{1, 3};
        int id, data, lat; bit err, ok;
        ones_len = 2; done_at = 2;
        rst_n = 1'b1; #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rr_first_ready got %b want 0001", req_ready); end
        for (int k = 0; k < 4; k++) begin
            run_op(1'b1, id, data, err, lat, ok);
            total++; if (!ok || id !== exp1[k] || data !== 2 || lat !== 3)
                begin bad++; $display("FAIL rr_all_op%0d got ok=%0b id=%0d data=%0d lat=%0d want 1 %0d 2 3", k, ok, id, data, lat, exp1[k]); end
        end
        req_valid = 4'b1010;
        for (int k = 0; k < 2; k++) begin
            run_op(1'b1, id, data, err, lat, ok);
            total++; if (!ok || id !== exp2[k])
                begin bad++; $display("FAIL rr_sparse_op%0d got ok=%0b id=%0d want 1 %0d", k, ok, id, exp2[k]); end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_single();
        int lat; bit hold_ok;
        ones_len = 7; done_at = 7;
        req_data[2][0] = 5'd3; req_data[2][1] = 5'd5;
        req_valid = 4'b0100; #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got %b want 0100", req_ready); end
        step();
        req_valid = 4'b0000;
        total++; if ({busy, core_en, core_rst} !== 3'b110)
            begin bad++; $display("FAIL single_start got busy=%b en=%b rst=%b want 1 1 0", busy, core_en, core_rst); end
        total++; if (core_data[0] !== 5'd3 || core_data[1] !== 5'd5)
            begin bad++; $display("FAIL single_operands got %0d,%0d want 3,5", core_data[0], core_data[1]); end
        lat = 0; hold_ok = 1'b1;
        while (!resp_valid && lat < 100) begin
            step(); lat++;
            if (core_en && (core_data[0] !== 5'd3 || core_data[1] !== 5'd5)) hold_ok = 1'b0;
        end
        total++; if (!hold_ok) begin bad++; $display("FAIL single_hold got changed want held 3,5"); end
        total++; if (lat !== 8) begin bad++; $display("FAIL single_latency got %0d want 8", lat); end
        total++; if (resp_id !== 2'd2 || resp_data !== 5'd7 || resp_err !== 1'b0 || core_en !== 1'b0)
            begin bad++; $display("FAIL single_resp got id=%0d data=%0d err=%b en=%b want 2 7 0 0", resp_id, resp_data, resp_err, core_en); end
        resp_ready = 1'b1; step(); resp_ready = 1'b0;
        total++; if (busy !== 1'b0 || resp_valid !== 1'b0)
            begin bad++; $display("FAIL single_release got busy=%b v=%b want 0 0", busy, resp_valid); end
    endtask

    task automatic test_timeout();
        int id, data, lat; bit err, ok;
        ones_len = 3; done_at = -1;
        req_valid = 4'b0001;
        run_op(1'b1, id, data, err, lat, ok);
        req_valid = 4'b0000;
        total++; if (!ok || lat !== 16) begin bad++; $display("FAIL timeout_latency got ok=%0b lat=%0d want 1 16", ok, lat); end
        total++; if (id !== 0 || data !== 0 || err !== 1'b1)
            begin bad++; $display("FAIL timeout_resp got id=%0d data=%0d err=%b want 0 0 1", id, data, err); end
    endtask

    task automatic test_resp_hold();
        int id, data, lat; bit err, ok;
        ones_len = 3; done_at = 4;
        req_valid = 4'b1111;
        run_op(1'b0, id, data, err, lat, ok);
        total++; if (!ok || id !== 1 || data !== 3 || err !== 1'b0 || lat !== 5)
            begin bad++; $display("FAIL hold_resp got ok=%0b id=%0d data=%0d err=%b lat=%0d want 1 1 3 0 5", ok, id, data, err, lat); end
        for (int k = 0; k < 10; k++) begin
            step();
            total++;
            if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== 5'd3 || resp_err !== 1'b0 ||
                req_ready !== 4'b0000 || core_rst !== 1'b1 || core_en !== 1'b0) begin
                bad++;
                $display("FAIL hold_cycle%0d got v=%b id=%0d d=%0d e=%b rdy=%b rst=%b en=%b want 1 1 3 0 0000 1 0",
                         k, resp_valid, resp_id, resp_data, resp_err, req_ready, core_rst, core_en);
            end
        end
        resp_ready = 1'b1; step(); resp_ready = 1'b0;
        total++; if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 4'b0100)
            begin bad++; $display("FAIL hold_release got busy=%b v=%b rdy=%b want 0 0 0100", busy, resp_valid, req_ready); end
        req_valid = 4'b0000;
    endtask

    task automatic test_reset_mid_run();
        int w, id, data, lat; bit err, ok, quiet;
        ones_len = 20; done_at = -1;
        req_valid = 4'b0010;
        w = 0;
        while (!busy && w < 50) begin step(); w++; end
        req_valid = 4'b0000;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_start got busy=%b want 1", busy); end
        repeat (5) step();
        rst_n = 1'b0; #1;
        total++; if ({core_rst, core_en, busy, resp_valid} !== 4'b1000)
            begin bad++; $display("FAIL midrst_immediate got rst=%b en=%b busy=%b v=%b want 1 0 0 0", core_rst, core_en, busy, resp_valid); end
        step(); step();
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (resp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        total++; if (!quiet) begin bad++; $display("FAIL midrst_no_resp got activity want none"); end
        ones_len = 1; done_at = 2;
        req_valid = 4'b1111; #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL midrst_ptr got %b want 0001", req_ready); end
        run_op(1'b1, id, data, err, lat, ok);
        req_valid = 4'b0000;
        total++; if (!ok || id !== 0 || data !== 1)
            begin bad++; $display("FAIL midrst_next got ok=%0b id=%0d data=%0d want 1 0 1", ok, id, data); end
    endtask

    task automatic test_saturation();
        int w, lat;
        b_req_valid = 4'b0001;
        w = 0;
        while (!b_busy && w < 50) begin step(); w++; end
        b_req_valid = 4'b0000;
        lat = 0;
        while (!b_resp_valid && lat < 400) begin step(); lat++; end
        total++; if (b_resp_valid !== 1'b1 || lat !== 300)
            begin bad++; $display("FAIL sat_latency got v=%b lat=%0d want 1 300", b_resp_valid, lat); end
        total++; if (b_resp_data !== 8'd255 || b_resp_err !== 1'b0 || b_resp_id !== 2'd0)
            begin bad++; $display("FAIL sat_resp got data=%0d err=%b id=%0d want 255 0 0", b_resp_data, b_resp_err, b_resp_id); end
        b_resp_ready = 1'b1; step(); b_resp_ready = 1'b0;
        total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL sat_release got busy=%b want 0", b_busy); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_timeout();
        test_resp_hold();
        test_reset_mid_run();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
